// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings and baud divisor helper
//
// Purpose: parity-mode encodings, transmitter FSM state encoding and the
//          clocks-per-bit divisor function. The configurable RX uses the same package.
// Ports:   none (package)
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_ODD  = 2'd1;
   localparam logic [1:0] PAR_EVEN = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   function automatic int baud_div(input int clk_freq, input int bps);
      return clk_freq / bps;
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - word handshake between byte source and UART transmitter
//
// Purpose: carries one word plus its parity mode per valid/ready handshake.
// Signals: s_data   word to send
//          s_valid  source has a word
//          s_ready  transmitter can accept
//          par_mode parity selection for this word
// Modports: master = source side, slave = transmitter side
interface uart_tx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic [1:0]           par_mode;

   modport master (output s_data, output s_valid, output par_mode, input s_ready);
   modport slave  (input s_data, input s_valid, input par_mode, output s_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter for the UART transmitter
//
// Purpose: counts 0..BAUD_CNT_MAX-1 while enabled and flags the last clock of a bit.
// Ports:   sys_clk, sys_rst_n  clock, async active-low reset
//          en                  count while high
//          restart             force counter back to 0 (new frame accepted)
//          bit_end             high in the final clock of the current bit
module uart_baud_gen #(
   parameter int BAUD_CNT_MAX = 16
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic en,
   input  logic restart,
   output logic bit_end
);
   localparam int W = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;
   localparam logic [W-1:0] CNT_LAST = W'(BAUD_CNT_MAX - 1);

   logic [W-1:0] cnt;

   assign bit_end = en && (cnt == CNT_LAST);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= bit_end ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (data bits, parity, stop bits)
//
// Purpose: serialises one word per handshake: start bit, DATA_BITS data bits LSB first,
//          optional odd/even parity, STOP_BITS stop bits; back-to-back frames without gaps.
// Ports:   sys_clk, sys_rst_n  clock, async active-low reset
//          s                   word handshake (slave side)
//          busy                frame in progress
//          tx_done             one-cycle pulse in the final clock of the last stop bit
//          tx                  serial line, idle high
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int UART_BPS  = 9600,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   uart_tx_cfg_if.slave  s,
   output logic          busy,
   output logic          tx_done,
   output logic          tx
);
   localparam int BAUD_CNT_MAX = baud_div(CLK_FREQ, UART_BPS);
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   if (BAUD_CNT_MAX < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
      $error("uart_tx_cfg: illegal configuration");
   end

   tx_state_e            state, state_nxt;
   logic [3:0]           idx, idx_nxt;
   logic [DATA_BITS-1:0] data_q;
   logic [DATA_BITS-1:0] shifted;
   logic [1:0]           par_q;
   logic                 par_en, par_bit;
   logic                 ready, accept, bit_end;

   uart_baud_gen #(.BAUD_CNT_MAX(BAUD_CNT_MAX)) u_baud (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .en        (busy),
      .restart   (accept),
      .bit_end   (bit_end)
   );

   assign busy      = (state != ST_IDLE);
   assign s.s_ready = ready;
   assign shifted   = data_q >> idx;
   // Mode 3 is deliberately treated as no parity.
   assign par_en    = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
   assign par_bit   = (par_q == PAR_ODD) ? ~^data_q : ^data_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state  <= ST_IDLE;
         idx    <= '0;
         data_q <= '0;
         par_q  <= PAR_NONE;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (accept) begin
            data_q <= s.s_data;
            par_q  <= s.par_mode;
         end
      end
   end

   // idx counts data bits in DATA and stop bits in STOP.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      ready     = 1'b0;
      tx_done   = 1'b0;
      tx        = 1'b1;
      case (state)
         ST_IDLE: ready = 1'b1;
         ST_START: begin
            tx = 1'b0;
            if (bit_end) begin
               state_nxt = ST_DATA;
               idx_nxt   = '0;
            end
         end
         ST_DATA: begin
            tx = shifted[0];
            if (bit_end) begin
               if (idx == LAST_DATA) begin
                  idx_nxt   = '0;
                  state_nxt = par_en ? ST_PARITY : ST_STOP;
               end else begin
                  idx_nxt = idx + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            tx = par_bit;
            if (bit_end) begin
               state_nxt = ST_STOP;
               idx_nxt   = '0;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (idx == LAST_STOP) begin
                  tx_done   = 1'b1;
                  ready     = 1'b1;
                  state_nxt = ST_IDLE;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 4'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Accepting in the final stop clock chains straight into the next start bit.
      accept = s.s_valid & ready;
      if (accept) begin
         state_nxt = ST_START;
         idx_nxt   = '0;
      end
   end
endmodule
